// File: rtl/sitcpxg_rx_buffer_reader.sv
// Receive-side user buffer for the SiTCP 10GbE core: stores the core's byte-enabled
// writes, streams them out as left-justified beats and hands the consumed pointer back.
module sitcpxg_rx_buffer_reader #(
    parameter int BUF_AW = 13
) (
    input  logic        XGMII_CLOCK,
    input  logic        RSTs,
    input  logic [15:0] RX_WADR,
    input  logic [7:0]  RX_WENB,
    input  logic [63:0] RX_WDAT,
    output logic [15:0] RX_RADR,
    output logic [15:0] RX_SIZE,
    input  logic        RX_CLR_ENB,
    output logic        RX_CLR_REQ,
    output logic [63:0] OUT_D,
    output logic [3:0]  OUT_B,
    output logic        OUT_VALID,
    input  logic        OUT_READY
);

    localparam int WORDS    = 1 << (BUF_AW - 3);
    localparam int SIZE_VAL = (1 << BUF_AW) - 16;

    typedef logic [BUF_AW-1:0] ptr_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_CLR,
        ST_HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        active;
    logic        clr_req;

    ptr_t        wr_ptr;
    ptr_t        iss_ptr;
    ptr_t        rd_ptr;
    ptr_t        wr_new;
    ptr_t        avail;
    logic [2:0]  low_idx;
    logic [3:0]  room;
    logic [3:0]  beat_len;
    logic [1:0]  occ;
    logic        issue;
    logic        drained;

    logic [63:0] mem [0:WORDS-1];
    logic [63:0] rd_word;
    logic        rd_valid;
    logic [2:0]  rd_shift;
    logic [3:0]  rd_len;
    logic [63:0] beat_d;

    logic [63:0] skid_d [0:1];
    logic [3:0]  skid_b [0:1];
    logic [1:0]  skid_cnt;
    logic        pop;
    logic        push;

    logic        unused_wadr;

    assign unused_wadr = ^RX_WADR;

    assign RX_SIZE    = 16'(SIZE_VAL);
    assign RX_RADR    = 16'(rd_ptr);
    assign RX_CLR_REQ = clr_req;

    assign OUT_VALID = (skid_cnt != 2'd0);
    assign OUT_D     = OUT_VALID ? skid_d[0] : 64'h0;
    assign OUT_B     = OUT_VALID ? skid_b[0] : 4'h0;

    assign pop  = OUT_VALID & OUT_READY;
    assign push = rd_valid;

    // The committed write pointer lands just past the lowest enabled byte of the word.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (RX_WENB[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    assign wr_new = {RX_WADR[BUF_AW-1:3], 3'b000} + ptr_t'(4'd8 - {1'b0, low_idx});

    assign avail    = wr_ptr - iss_ptr;
    assign room     = 4'd8 - {1'b0, iss_ptr[2:0]};
    assign beat_len = (avail < ptr_t'(room)) ? avail[3:0] : room;

    // Occupancy counts the slot freed by this cycle's pop, so a steady stream issues every cycle.
    assign occ     = skid_cnt - 2'(pop) + 2'(rd_valid);
    assign issue   = active && (avail != '0) && (occ < 2'd2);
    assign drained = (iss_ptr == wr_ptr) && !rd_valid && (skid_cnt == 2'd0);

    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        active     = 1'b0;
        clr_req    = 1'b0;
        case (state)
            ST_RUN: begin
                active = 1'b1;
                if (RX_CLR_ENB) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                active = 1'b1;
                if (!RX_CLR_ENB) begin
                    state_next = ST_RUN;
                end else if (drained) begin
                    state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                clr_req    = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!RX_CLR_ENB) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            wr_ptr  <= '0;
            iss_ptr <= '0;
            rd_ptr  <= '0;
        end else if (clr_req) begin
            wr_ptr  <= '0;
            iss_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            if (active && (RX_WENB != 8'h00)) begin
                wr_ptr <= wr_new;
            end
            if (issue) begin
                iss_ptr <= iss_ptr + ptr_t'(beat_len);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(OUT_B);
            end
        end
    end

    // Memory keeps accepting writes in every state; only the pointer tracking is gated.
    always_ff @(posedge XGMII_CLOCK) begin
        for (int i = 0; i < 8; i++) begin
            if (RX_WENB[i]) begin
                mem[RX_WADR[BUF_AW-1:3]][8*i +: 8] <= RX_WDAT[8*i +: 8];
            end
        end
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (issue) begin
            rd_word <= mem[iss_ptr[BUF_AW-1:3]];
        end
    end

    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            rd_valid <= 1'b0;
            rd_shift <= 3'd0;
            rd_len   <= 4'd0;
        end else begin
            rd_valid <= issue;
            if (issue) begin
                rd_shift <= iss_ptr[2:0];
                rd_len   <= beat_len;
            end
        end
    end

    assign beat_d = (rd_word << {rd_shift, 3'b000}) & ~(64'hFFFF_FFFF_FFFF_FFFF >> {rd_len, 3'b000});

    // Two-entry skid, entry 0 is always the head.
    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            skid_cnt  <= 2'd0;
            skid_d[0] <= 64'h0;
            skid_d[1] <= 64'h0;
            skid_b[0] <= 4'h0;
            skid_b[1] <= 4'h0;
        end else begin
            if (pop) begin
                skid_d[0] <= skid_d[1];
                skid_b[0] <= skid_b[1];
            end
            if (push) begin
                if ((skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && pop)) begin
                    skid_d[0] <= beat_d;
                    skid_b[0] <= rd_len;
                end else begin
                    skid_d[1] <= beat_d;
                    skid_b[1] <= rd_len;
                end
            end
            skid_cnt <= skid_cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_sitcpxg_rx_buffer_reader.sv
// Directed bench for sitcpxg_rx_buffer_reader built with a 4 KiB buffer so the
// pointer wrap can be reached by streaming.
module tb_sitcpxg_rx_buffer_reader;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rx_wadr;
    logic [7:0]  rx_wenb;
    logic [63:0] rx_wdat;
    logic [15:0] rx_radr;
    logic [15:0] rx_size;
    logic        rx_clr_enb;
    logic        rx_clr_req;
    logic [63:0] out_d;
    logic [3:0]  out_b;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    sitcpxg_rx_buffer_reader #(.BUF_AW(AW)) dut (
        .XGMII_CLOCK (clk),
        .RSTs        (rst),
        .RX_WADR     (rx_wadr),
        .RX_WENB     (rx_wenb),
        .RX_WDAT     (rx_wdat),
        .RX_RADR     (rx_radr),
        .RX_SIZE     (rx_size),
        .RX_CLR_ENB  (rx_clr_enb),
        .RX_CLR_REQ  (rx_clr_req),
        .OUT_D       (out_d),
        .OUT_B       (out_b),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] wadr, input logic [7:0] wenb, input logic [63:0] wdat);
        rx_wadr = wadr;
        rx_wenb = wenb;
        rx_wdat = wdat;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Waits a bounded number of cycles for a beat, checks it, and lets it be accepted.
    task automatic expect_beat(input string tag, input logic [63:0] exp_d, input logic [3:0] exp_b);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_output({tag, "_valid"}, out_valid, 1);
        check_output({tag, "_d"}, out_d, exp_d);
        check_output({tag, "_b"}, out_b, exp_b);
        tick();
    endtask

    function automatic logic [63:0] bp_word(input int k);
        return 64'h0101010101010101 * (64'(k) + 64'h20);
    endfunction

    initial begin
        rst        = 1'b1;
        rx_wadr    = 16'h0;
        rx_wenb    = 8'h00;
        rx_wdat    = 64'h0;
        rx_clr_enb = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();

        check_output("reset_radr", rx_radr, 0);
        check_output("reset_clr_req", rx_clr_req, 0);
        check_output("reset_valid", out_valid, 0);
        check_output("reset_out_d", out_d, 0);
        check_output("reset_out_b", out_b, 0);
        check_output("rx_size", rx_size, 16'd4080);
        rst = 1'b0;
        tick();

        // Aligned stream: four full words, one beat per cycle.
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                apply_stimulus(16'(c * 8), 8'hFF, 64'h0001020304050607 + 64'(c) * 64'h0808080808080808);
            end else begin
                apply_stimulus(16'h0, 8'h00, 64'h0);
            end
            if (c == 2) begin
                check_output("aligned_latency", out_valid, 0);
            end
            if (c >= 3 && c <= 6) begin
                check_output("aligned_valid", out_valid, 1);
                check_output("aligned_d", out_d, 64'h0001020304050607 + 64'(c - 3) * 64'h0808080808080808);
                check_output("aligned_b", out_b, 8);
            end
            if (c == 4) begin
                check_output("aligned_radr_mid", rx_radr, 8);
            end
            if (c == 7) begin
                check_output("aligned_radr", rx_radr, 32);
                check_output("aligned_idle", out_valid, 0);
            end
            tick();
        end

        // Partial word, then the rest of the same word.
        pulse_reset();
        apply_stimulus(16'h0, 8'hF0, 64'hA0A1A2A3_5A5A5A5A);
        tick();
        apply_stimulus(16'h0, 8'h00, 64'h0);
        expect_beat("partial_lo", 64'hA0A1A2A3_00000000, 4);
        check_output("partial_radr_lo", rx_radr, 4);
        apply_stimulus(16'h0, 8'h0F, 64'h5A5A5A5A_C4C5C6C7);
        tick();
        apply_stimulus(16'h0, 8'h00, 64'h0);
        expect_beat("partial_hi", 64'hC4C5C6C7_00000000, 4);
        check_output("partial_radr", rx_radr, 8);

        // Backpressure: six-word burst with READY low for ten cycles.
        pulse_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                apply_stimulus(16'(c * 8), 8'hFF, bp_word(c));
            end else begin
                apply_stimulus(16'h0, 8'h00, 64'h0);
            end
            if (c >= 3) begin
                check_output("bp_hold_valid", out_valid, 1);
                check_output("bp_hold_d", out_d, bp_word(0));
                check_output("bp_hold_b", out_b, 8);
                check_output("bp_hold_radr", rx_radr, 0);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            expect_beat("bp_beat", bp_word(k), 8);
        end
        check_output("bp_radr", rx_radr, 48);

        // Clear handshake with 24 bytes pending.
        pulse_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(16'(c * 8), 8'hFF, 64'h1111111111111111 * 64'(c + 1));
            tick();
        end
        apply_stimulus(16'h0, 8'h00, 64'h0);
        tick();
        tick();
        tick();
        rx_clr_enb = 1'b1;
        out_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_beat("clr_beat", 64'h1111111111111111 * 64'(k + 1), 8);
        end
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (rx_clr_req) begin
                pulses++;
                check_output("clr_radr_before", rx_radr, 24);
            end
            tick();
        end
        check_output("clr_pulse_count", pulses, 1);
        check_output("clr_radr_after", rx_radr, 0);
        apply_stimulus(16'h0, 8'hFF, 64'h7777777777777777);
        tick();
        apply_stimulus(16'h0, 8'h00, 64'h0);
        for (int c = 0; c < 5; c++) begin
            check_output("hold_no_issue", out_valid, 0);
            tick();
        end
        rx_clr_enb = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_output("hold_write_ignored", out_valid, 0);
            tick();
        end
        apply_stimulus(16'h0, 8'hFF, 64'h0123456789ABCDEF);
        tick();
        apply_stimulus(16'h0, 8'h00, 64'h0);
        expect_beat("post_clr", 64'h0123456789ABCDEF, 8);
        check_output("post_clr_radr", rx_radr, 8);

        // Clear enable withdrawn while still draining.
        out_ready = 1'b0;
        apply_stimulus(16'h8, 8'hFF, 64'hFEDCBA9876543210);
        tick();
        apply_stimulus(16'h0, 8'h00, 64'h0);
        tick();
        tick();
        tick();
        rx_clr_enb = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rx_clr_req) pulses++;
        end
        rx_clr_enb = 1'b0;
        tick();
        out_ready = 1'b1;
        expect_beat("abort_beat", 64'hFEDCBA9876543210, 8);
        for (int c = 0; c < 8; c++) begin
            if (rx_clr_req) pulses++;
            tick();
        end
        check_output("abort_no_clr", pulses, 0);
        check_output("abort_radr", rx_radr, 16);

        // Wrap: stream up to 4088, then one word at the top and one at the bottom.
        pulse_reset();
        out_ready = 1'b1;
        for (int w = 0; w < 511; w++) begin
            apply_stimulus(16'(w * 8), 8'hFF, 64'(w));
            tick();
        end
        apply_stimulus(16'h0, 8'h00, 64'h0);
        for (int c = 0; c < 6; c++) tick();
        check_output("wrap_radr_pre", rx_radr, 16'd4088);
        check_output("wrap_idle", out_valid, 0);
        apply_stimulus(16'd4088, 8'hFF, 64'hDEADBEEF_00C0FFEE);
        tick();
        apply_stimulus(16'hF000, 8'hFF, 64'hCAFEF00D_12345678);
        tick();
        apply_stimulus(16'h0, 8'h00, 64'h0);
        expect_beat("wrap_top", 64'hDEADBEEF_00C0FFEE, 8);
        expect_beat("wrap_bottom", 64'hCAFEF00D_12345678, 8);
        check_output("wrap_radr", rx_radr, 8);

        // Reset with two beats sitting in the skid.
        pulse_reset();
        out_ready = 1'b1;
        apply_stimulus(16'h0, 8'hFF, 64'h5555555555555555);
        tick();
        apply_stimulus(16'h0, 8'h00, 64'h0);
        expect_beat("mid_first", 64'h5555555555555555, 8);
        out_ready = 1'b0;
        for (int c = 1; c < 4; c++) begin
            apply_stimulus(16'(c * 8), 8'hFF, 64'h6666666666666666);
            tick();
        end
        apply_stimulus(16'h0, 8'h00, 64'h0);
        tick();
        tick();
        tick();
        check_output("mid_pre_valid", out_valid, 1);
        check_output("mid_pre_radr", rx_radr, 8);
        pulse_reset();
        check_output("mid_rst_valid", out_valid, 0);
        check_output("mid_rst_radr", rx_radr, 0);
        check_output("mid_rst_d", out_d, 0);
        check_output("mid_rst_b", out_b, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_output("mid_rst_quiet", out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
